// File: rtl/afisaj_cronometru_if.sv
// Bus between the stopwatch counters and the display stage: binary counter
// values in, multiplexed 7-segment drive and converter status out.
interface afisaj_cronometru_if;
    logic [5:0] sec_bin;
    logic [5:0] min_bin;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_busy;

    // Counter / environment side: drives the binary values, watches the display.
    modport master (
        output sec_bin,
        output min_bin,
        input  an,
        input  seg,
        input  dp,
        input  conv_busy
    );

    // Display stage side.
    modport slave (
        input  sec_bin,
        input  min_bin,
        output an,
        output seg,
        output dp,
        output conv_busy
    );
endinterface

// File: rtl/afisaj_cronometru.sv
// Stopwatch display stage: converts the seconds/minutes counters to BCD with a
// subtract-by-10 engine and scans four active-low 7-segment digits as MM.SS.
// Converted digits land in the display registers in a single cycle, so a digit
// pair is never shown half-updated.
module afisaj_cronometru #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk_out,
    input  logic                 reset,
    afisaj_cronometru_if.slave   bus
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    // Digit code 4'hA stands for a dash in the display registers.
    localparam logic [3:0]    DASH     = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          first_q, first_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          wrap;
    logic          req;
    logic [3:0]    digit;
    logic [1:0]    below10;

    // Channel 0 = seconds, channel 1 = minutes.
    logic [5:0]    chan_in    [2];
    logic [3:0]    disp_units [2];
    logic [3:0]    disp_tens  [2];

    assign chan_in[0] = bus.sec_bin;
    assign chan_in[1] = bus.min_bin;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [5:0] work_q, work_d;
            logic [3:0] tens_q, tens_d;
            logic       oor_q, oor_d;
            logic [3:0] units_disp_q, units_disp_d;
            logic [3:0] tens_disp_q, tens_disp_d;

            // Per-channel datapath: capture, repeated subtract-by-10, commit.
            always_comb begin
                work_d       = work_q;
                tens_d       = tens_q;
                oor_d        = oor_q;
                units_disp_d = units_disp_q;
                tens_disp_d  = tens_disp_q;
                case (state_q)
                    LOAD: begin
                        work_d = chan_in[gi];
                        tens_d = 4'd0;
                        oor_d  = (chan_in[gi] > 6'd59);
                    end
                    CONV: begin
                        if (work_q >= 6'd10) begin
                            work_d = work_q - 6'd10;
                            tens_d = tens_q + 4'd1;
                        end
                    end
                    DONE: begin
                        units_disp_d = oor_q ? DASH : work_q[3:0];
                        tens_disp_d  = oor_q ? DASH : tens_q;
                    end
                    default: ;
                endcase
            end

            // Per-channel registers; reset also drops any partial result.
            always_ff @(posedge clk_out) begin
                if (reset) begin
                    work_q       <= 6'd0;
                    tens_q       <= 4'd0;
                    oor_q        <= 1'b0;
                    units_disp_q <= 4'd0;
                    tens_disp_q  <= 4'd0;
                end else begin
                    work_q       <= work_d;
                    tens_q       <= tens_d;
                    oor_q        <= oor_d;
                    units_disp_q <= units_disp_d;
                    tens_disp_q  <= tens_disp_d;
                end
            end

            assign below10[gi]    = (work_q < 6'd10);
            assign disp_units[gi] = units_disp_q;
            assign disp_tens[gi]  = tens_disp_q;
        end
    endgenerate

    // Refresh counter, digit scan and conversion request.
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        first_d = 1'b0;
        req     = first_q || (wrap && (idx_q == 2'd3));
    end

    // Conversion FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = LOAD;
            LOAD:    state_d = CONV;
            CONV:    if (&below10) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit select and segment decode for the registered display outputs.
    always_comb begin
        an_d  = 4'b1110;
        dp_d  = 1'b1;
        digit = disp_units[0];
        case (idx_q)
            2'd0: begin an_d = 4'b1110; digit = disp_units[0]; end
            2'd1: begin an_d = 4'b1101; digit = disp_tens[0];  end
            2'd2: begin an_d = 4'b1011; digit = disp_units[1]; dp_d = 1'b0; end
            2'd3: begin an_d = 4'b0111; digit = disp_tens[1];  end
            default: ;
        endcase
        seg_d = seg_of(digit);
    end

    // Control and output registers; first_q requests a conversion right after reset.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            first_q <= 1'b1;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.conv_busy = (state_q != IDLE);

endmodule

// File: tb/tb_afisaj_cronometru.sv
// Bench for the stopwatch display stage: vector table of counter values with
// hand-written expected digits and conversion lengths, plus reset sequences.
module tb_afisaj_cronometru;

    localparam int RD = 4;

    logic clk_out = 1'b0;
    logic reset   = 1'b1;

    afisaj_cronometru_if bus();

    afisaj_cronometru #(.REFRESH_DIV(RD)) dut (
        .clk_out (clk_out),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_out = ~clk_out;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    // Digits: d0 = sec units, d1 = sec tens, d2 = min units, d3 = min tens; 10 = dash.
    typedef struct {
        int sec;
        int min;
        bit poke;
        int busy;
        int d0;
        int d1;
        int d2;
        int d3;
    } vec_t;

    exp_t       sb [$];
    vec_t       vecs [7];
    logic [6:0] segtab [0:10];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout", name);
    endtask

    task automatic push_digits(input int d0, input int d1, input int d2, input int d3);
        int d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.an  = ~(4'b0001 << k);
            e.seg = segtab[d[k]];
            e.dp  = (k == 2) ? 1'b0 : 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.conv_busy === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_out);
        end
        if (!ok) fail_now(name);
    endtask

    // Compare one full scan against the four queued expectations.
    task automatic scan(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.an === 4'b1110) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_out);
        end
        if (!ok) begin
            fail_now({tag, " scan_start"});
            for (int k = 0; k < 4; k++) void'(sb.pop_front());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("%s an%0d", tag, k), int'(bus.an), int'(e.an));
                check($sformatf("%s seg%0d", tag, k), int'(bus.seg), int'(e.seg));
                check($sformatf("%s dp%0d", tag, k), int'(bus.dp), int'(e.dp));
                $display("scan %s digit%0d an=%b seg=%b dp=%b", tag, k, bus.an, bus.seg, bus.dp);
                repeat (RD) @(negedge clk_out);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        string tag;

        segtab[0]  = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3]  = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9]  = 7'b0010000; segtab[10] = 7'b0111111;

        vecs[0] = '{37, 12, 1'b0, 6, 7, 3, 2, 1};
        vecs[1] = '{59, 59, 1'b1, 8, 9, 5, 9, 5};
        vecs[2] = '{60,  5, 1'b0, 9, 10, 10, 5, 0};
        vecs[3] = '{ 9,  0, 1'b0, 3, 9, 0, 0, 0};
        vecs[4] = '{63, 63, 1'b0, 9, 10, 10, 10, 10};
        vecs[5] = '{10, 59, 1'b0, 8, 0, 1, 9, 5};
        vecs[6] = '{ 0, 45, 1'b0, 7, 0, 0, 5, 4};

        // Reset state.
        bus.sec_bin = 6'd0;
        bus.min_bin = 6'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk_out);
        check("rst an", int'(bus.an), 15);
        check("rst seg", int'(bus.seg), 127);
        check("rst dp", int'(bus.dp), 1);
        check("rst busy", int'(bus.conv_busy), 0);
        $display("reset an=%b seg=%b dp=%b busy=%b", bus.an, bus.seg, bus.dp, bus.conv_busy);
        reset = 1'b0;
        @(negedge clk_out);
        check("busy after release", int'(bus.conv_busy), 1);
        push_digits(0, 0, 0, 0);
        wait_busy(1'b0, "post-reset conv end");
        @(negedge clk_out);
        scan("init");

        // Vector table.
        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("v%0d_%0d_%0d", v, vecs[v].sec, vecs[v].min);
            wait_busy(1'b0, {tag, " idle"});
            bus.sec_bin = 6'(vecs[v].sec);
            bus.min_bin = 6'(vecs[v].min);
            push_digits(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
            wait_busy(1'b1, {tag, " start"});
            cnt = 0;
            while (bus.conv_busy === 1'b1 && cnt < 64) begin
                cnt++;
                if (vecs[v].poke && cnt == 2) bus.sec_bin = 6'd0;
                @(negedge clk_out);
            end
            check({tag, " busy_len"}, cnt, vecs[v].busy);
            $display("conv %s busy_cycles=%0d", tag, cnt);
            if (vecs[v].poke) bus.sec_bin = 6'(vecs[v].sec);
            @(negedge clk_out);
            scan(tag);
        end

        // Reset in the middle of a 45/23 conversion.
        wait_busy(1'b0, "midrst idle");
        bus.sec_bin = 6'd45;
        bus.min_bin = 6'd23;
        wait_busy(1'b1, "midrst start");
        @(negedge clk_out);
        @(negedge clk_out);
        reset = 1'b1;
        @(negedge clk_out);
        check("midrst busy", int'(bus.conv_busy), 0);
        check("midrst an", int'(bus.an), 15);
        check("midrst seg", int'(bus.seg), 127);
        $display("midrst an=%b seg=%b busy=%b", bus.an, bus.seg, bus.conv_busy);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_out);
            if (bus.an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})
                check($sformatf("midrst zero c%0d", i), int'(bus.seg), int'(segtab[0]));
        end
        push_digits(5, 4, 3, 2);
        wait_busy(1'b0, "midrst conv end");
        @(negedge clk_out);
        scan("after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
